// File: rtl/down_counter_enable_gen.sv
// -----------------------------------------------------------------------------
// down_counter_enable_gen
//
// Produces the 'enable' input of down_counter. A programmable prescaler emits
// one enable pulse every div+1 clocks. In burst mode (burst != 0) it stops
// after 'burst' pulses and emits a one-cycle done pulse. In continuous mode
// (burst == 0) it runs until stopped. Operation is started and aborted by
// single-cycle start/stop strobes.
//
// Ports
//   clk          in   1      system clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   start        in   1      strobe: begin operation (honoured only in IDLE)
//   stop         in   1      strobe: abort operation, return to IDLE
//   div          in   DIV_W  enable period minus 1, captured at accepted start
//   burst        in   CNT_W  pulse count (0 = continuous), captured at start
//   enable       out  1      registered enable pulse
//   busy         out  1      high while in RUN
//   done         out  1      registered one-cycle pulse after the final burst pulse
//   pulses_left  out  CNT_W  remaining burst pulses; 0 in continuous mode / IDLE
// -----------------------------------------------------------------------------
module down_counter_enable_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [CNT_W-1:0] burst,
  output logic             enable,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q,       state_d;
  logic [DIV_W-1:0]   div_q,         div_d;
  logic [DIV_W-1:0]   presc_q,       presc_d;
  logic [CNT_W-1:0]   pulses_left_q, pulses_left_d;
  logic               burst_mode_q,  burst_mode_d;
  logic               enable_q,      enable_d;
  logic               busy_q,        busy_d;
  logic               done_q,        done_d;

  // Next-state and next-output computation for the IDLE/RUN/DONE sequencer.
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    presc_d       = presc_q;
    pulses_left_d = pulses_left_q;
    burst_mode_d  = burst_mode_q;
    enable_d      = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // stop wins over a simultaneous start
        if (start && !stop) begin
          div_d         = div;
          presc_d       = div;
          pulses_left_d = burst;
          burst_mode_d  = (burst != {CNT_W{1'b0}});
          busy_d        = 1'b1;
          state_d       = ST_RUN;
        end else begin
          busy_d        = 1'b0;
        end
      end

      ST_RUN: begin
        if (stop) begin
          // abort: no done pulse
          state_d       = ST_IDLE;
          busy_d        = 1'b0;
          pulses_left_d = {CNT_W{1'b0}};
        end else if (presc_q == {DIV_W{1'b0}}) begin
          enable_d = 1'b1;
          presc_d  = div_q;
          if (burst_mode_q) begin
            // guard keeps the count from wrapping even if state were corrupted
            if (pulses_left_q != {CNT_W{1'b0}}) begin
              pulses_left_d = pulses_left_q - CNT_W'(1);
            end else begin
              pulses_left_d = {CNT_W{1'b0}};
            end
            if (pulses_left_q == CNT_W'(1)) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            pulses_left_d = {CNT_W{1'b0}};
          end
        end else begin
          presc_d = presc_q - DIV_W'(1);
        end
      end

      ST_DONE: begin
        busy_d        = 1'b0;
        done_d        = 1'b1;
        pulses_left_d = {CNT_W{1'b0}};
        state_d       = ST_IDLE;
      end

      default: begin
        // recover from an illegal encoding into a clean IDLE
        state_d       = ST_IDLE;
        busy_d        = 1'b0;
        pulses_left_d = {CNT_W{1'b0}};
        presc_d       = {DIV_W{1'b0}};
      end
    endcase
  end

  // State and registered-output flops with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      div_q         <= {DIV_W{1'b0}};
      presc_q       <= {DIV_W{1'b0}};
      pulses_left_q <= {CNT_W{1'b0}};
      burst_mode_q  <= 1'b0;
      enable_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      presc_q       <= presc_d;
      pulses_left_q <= pulses_left_d;
      burst_mode_q  <= burst_mode_d;
      enable_q      <= enable_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign enable      = enable_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulses_left = pulses_left_q;

endmodule
